uart8_rx_controller: RTL

UART8_RX_CONTROLLER -- requirements
Module: uart8_rx_controller

---
 rtl/uart8_rx_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart8_rx_controller.sv
// Receive-side controller for an 8-bit UART: gates the receiver through OFF/ARM/RUN/DRAIN,
// captures each completed byte into a small FIFO and keeps saturating error statistics.
module uart8_rx_controller #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr_stats,
    input  logic       rx_busy,
    input  logic       rx_done,
    input  logic       rx_err,
    input  logic [7:0] rx_out,
    input  logic       out_ready,
    output logic       rx_en,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic [4:0] level,
    output logic [7:0] overrun_count,
    output logic [7:0] err_count,
    output logic       active,
    output logic [1:0] state_dbg
);
    // Handshake: a byte leaves the FIFO on every clk edge where out_valid && out_ready;
    // out_valid never waits on out_ready, and out_data holds the head until it is popped.

    localparam int         PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL = 5'(DEPTH);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    logic            arm_cnt;
    logic [7:0]      drain_timer;
    logic            done_q;
    logic            err_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [7:0]      mem [DEPTH];

    logic listening;
    logic done_rise;
    logic err_rise;
    logic push_req;
    logic push_ok;
    logic pop;
    logic overrun;

    assign done_rise = rx_done & ~done_q;
    assign err_rise  = rx_err & ~err_q;
    assign listening = (state == RUN) || (state == DRAIN);
    assign push_req  = listening & done_rise;
    assign out_valid = (level != 5'd0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push_ok   = push_req & ((level != FULL) | pop);
    assign overrun   = push_req & (level == FULL) & ~pop;
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= rx_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= OFF;
            rx_en         <= 1'b0;
            active        <= 1'b0;
            arm_cnt       <= 1'b0;
            drain_timer   <= 8'd0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= 5'd0;
            overrun_count <= 8'd0;
            err_count     <= 8'd0;
        end else begin
            done_q <= rx_done;
            err_q  <= rx_err;

            case (state)
                OFF: begin
                    if (en) begin
                        state   <= ARM;
                        rx_en   <= 1'b1;
                        active  <= 1'b1;
                        arm_cnt <= 1'b0;
                    end
                end
                ARM: begin
                    if (!en) begin
                        state  <= OFF;
                        rx_en  <= 1'b0;
                        active <= 1'b0;
                    end else if (arm_cnt) begin
                        state <= RUN;
                    end else begin
                        arm_cnt <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        if (rx_busy) begin
                            state       <= DRAIN;
                            drain_timer <= 8'd0;
                        end else begin
                            state  <= OFF;
                            rx_en  <= 1'b0;
                            active <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // en is deliberately ignored here: a started drain always completes.
                    drain_timer <= drain_timer + 8'd1;
                    if (done_rise || err_rise || !rx_busy || drain_timer == 8'd191) begin
                        state  <= OFF;
                        rx_en  <= 1'b0;
                        active <= 1'b0;
                    end
                end
            endcase

            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                level <= level + 5'd1;
            end else if (pop && !push_ok) begin
                level <= level - 5'd1;
            end

            if (clr_stats) begin
                overrun_count <= 8'd0;
            end else if (overrun && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end

            if (clr_stats) begin
                err_count <= 8'd0;
            end else if (listening && err_rise && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
